axi_lite_arbiter: RTL and testbench

Two-master, one-slave AXI-lite arbiter sitting directly downstream of the core's memory access stage and the instruction fetch stage, in front of the single shared memory/peripheral crossbar port. It grants one whole transaction at a time, either a read (AR→R) or a write (AW+W→B), to one master. It forwards the granted master's channels to the slave and holds the grant until the response handshake completes. Arbitration is round-robin between the fetch master (M0) and the load/store master (M1).

---
 rtl/axi_arb_pkg.sv | 19 +
 rtl/axi_arb_rr2.sv | 20 ++
 rtl/axi_lite_arbiter.sv | 154 +++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared state encoding, master indices and response codes for axi_lite_arbiter
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4
  } arb_state_e;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_arb_rr2.sv
// rtl/axi_arb_rr2.sv - combinational two-requester round-robin pick
module axi_arb_rr2
  import axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  // On a tie the master not granted last time wins; a lone requester always wins.
  always_comb begin
    winner = M_IFU;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[M_LSU]) begin
      winner = M_LSU;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - two-master AXI-lite arbiter granting one whole read or write at a time
module axi_lite_arbiter
  import axi_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  // m0: fetch master
  input  logic [31:0] m0_araddr,
  input  logic [2:0]  m0_arsize,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [31:0] m0_awaddr,
  input  logic [2:0]  m0_awsize,
  input  logic        m0_awvalid,
  output logic        m0_awready,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_wvalid,
  output logic        m0_wready,
  output logic [1:0]  m0_bresp,
  output logic        m0_bvalid,
  input  logic        m0_bready,
  // m1: load/store master
  input  logic [31:0] m1_araddr,
  input  logic [2:0]  m1_arsize,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  input  logic [31:0] m1_awaddr,
  input  logic [2:0]  m1_awsize,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic [1:0]  m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  // s: shared downstream slave
  output logic [31:0] s_araddr,
  output logic [2:0]  s_arsize,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [31:0] s_awaddr,
  output logic [2:0]  s_awsize,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready
);

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_RD0  = RD0;
  localparam logic [2:0] ST_RD1  = RD1;
  localparam logic [2:0] ST_WR0  = WR0;
  localparam logic [2:0] ST_WR1  = WR1;

  logic [2:0] state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] rd_req, wr_req, req;
  logic       win;
  logic       sel, rd_act, wr_act;

  assign rd_req = {m1_arvalid, m0_arvalid};
  assign wr_req = {m1_awvalid | m1_wvalid, m0_awvalid | m0_wvalid};
  assign req    = rd_req | wr_req;

  axi_arb_rr2 u_rr2 (
    .req    (req),
    .last   (last_q),
    .winner (win)
  );

  // The grant is only released by the response handshake, never by AR/AW/W acceptance.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          last_d = win;
          if (wr_req[win]) state_d = (win == M_LSU) ? ST_WR1 : ST_WR0;
          else             state_d = (win == M_LSU) ? ST_RD1 : ST_RD0;
        end
      end
      ST_RD0, ST_RD1: if (s_rvalid && s_rready) state_d = ST_IDLE;
      ST_WR0, ST_WR1: if (s_bvalid && s_bready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= M_LSU;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign sel    = (state_q == ST_RD1) || (state_q == ST_WR1);
  assign rd_act = (state_q == ST_RD0) || (state_q == ST_RD1);
  assign wr_act = (state_q == ST_WR0) || (state_q == ST_WR1);

  // Payload muxes default to M0 in IDLE; only the handshake signals are gated.
  assign s_araddr  = sel ? m1_araddr : m0_araddr;
  assign s_arsize  = sel ? m1_arsize : m0_arsize;
  assign s_arvalid = rd_act & (sel ? m1_arvalid : m0_arvalid);
  assign s_rready  = rd_act & (sel ? m1_rready : m0_rready);
  assign s_awaddr  = sel ? m1_awaddr : m0_awaddr;
  assign s_awsize  = sel ? m1_awsize : m0_awsize;
  assign s_awvalid = wr_act & (sel ? m1_awvalid : m0_awvalid);
  assign s_wdata   = sel ? m1_wdata : m0_wdata;
  assign s_wstrb   = sel ? m1_wstrb : m0_wstrb;
  assign s_wvalid  = wr_act & (sel ? m1_wvalid : m0_wvalid);
  assign s_bready  = wr_act & (sel ? m1_bready : m0_bready);

  assign m0_arready = rd_act & ~sel & s_arready;
  assign m0_rvalid  = rd_act & ~sel & s_rvalid;
  assign m0_rdata   = s_rdata;
  assign m0_rresp   = s_rresp;
  assign m0_awready = wr_act & ~sel & s_awready;
  assign m0_wready  = wr_act & ~sel & s_wready;
  assign m0_bvalid  = wr_act & ~sel & s_bvalid;
  assign m0_bresp   = s_bresp;

  assign m1_arready = rd_act & sel & s_arready;
  assign m1_rvalid  = rd_act & sel & s_rvalid;
  assign m1_rdata   = s_rdata;
  assign m1_rresp   = s_rresp;
  assign m1_awready = wr_act & sel & s_awready;
  assign m1_wready  = wr_act & sel & s_wready;
  assign m1_bvalid  = wr_act & sel & s_bvalid;
  assign m1_bresp   = s_bresp;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - self-checking bench for axi_lite_arbiter with a scoreboarded slave model
module tb_axi_lite_arbiter;
  import axi_arb_pkg::*;

  localparam logic [31:0] RKEY = 32'h9234_5678;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] m0_araddr, m0_rdata, m0_awaddr, m0_wdata;
  logic [2:0]  m0_arsize, m0_awsize;
  logic [1:0]  m0_rresp, m0_bresp;
  logic [3:0]  m0_wstrb;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_awvalid, m0_awready;
  logic        m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic [31:0] m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
  logic [2:0]  m1_arsize, m1_awsize;
  logic [1:0]  m1_rresp, m1_bresp;
  logic [3:0]  m1_wstrb;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
  logic        m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [2:0]  s_arsize, s_awsize;
  logic [1:0]  s_rresp, s_bresp;
  logic [3:0]  s_wstrb;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic        s_wvalid, s_wready, s_bvalid, s_bready;

  axi_lite_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arsize(m0_arsize), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_awsize(m0_awsize), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m1_araddr(m1_araddr), .m1_arsize(m1_arsize), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awsize(m1_awsize), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awsize(s_awsize), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  // Slave model: read data is address ^ RKEY, so a wrong address mux also corrupts data.
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [1:0] rresp_cfg = RESP_OKAY, bresp_cfg = RESP_OKAY;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic r_pend, b_pend, aw_done, w_done;
  logic [31:0] r_addr, log_awaddr, log_wdata;
  logic [3:0]  log_wstrb;

  assign s_arready = s_arvalid && !r_pend && !s_rvalid && (ar_cnt >= ar_wait);
  assign s_awready = s_awvalid && !aw_done && (aw_cnt >= aw_wait);
  assign s_wready  = s_wvalid && !w_done && (w_cnt >= w_wait);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0; aw_done <= 1'b0; w_done <= 1'b0;
      s_rvalid <= 1'b0; s_bvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0; s_bresp <= '0;
      r_addr <= '0; log_awaddr <= '0; log_wdata <= '0; log_wstrb <= '0;
    end else begin
      if (s_arvalid && !s_arready) ar_cnt <= ar_cnt + 1;
      if (s_arvalid && s_arready) begin
        ar_cnt <= 0;
        r_addr <= s_araddr;
        if (r_wait == 0) begin
          s_rvalid <= 1'b1; s_rdata <= s_araddr ^ RKEY; s_rresp <= rresp_cfg;
        end else begin
          r_pend <= 1'b1; r_cnt <= r_wait - 1;
        end
      end
      if (r_pend) begin
        if (r_cnt == 0) begin
          r_pend <= 1'b0; s_rvalid <= 1'b1; s_rdata <= r_addr ^ RKEY; s_rresp <= rresp_cfg;
        end else r_cnt <= r_cnt - 1;
      end
      if (s_rvalid && s_rready) s_rvalid <= 1'b0;
      if (s_awvalid && !s_awready) aw_cnt <= aw_cnt + 1;
      if (s_awvalid && s_awready) begin aw_done <= 1'b1; log_awaddr <= s_awaddr; end
      if (s_wvalid && !s_wready) w_cnt <= w_cnt + 1;
      if (s_wvalid && s_wready) begin w_done <= 1'b1; log_wdata <= s_wdata; log_wstrb <= s_wstrb; end
      if (!b_pend && !s_bvalid && (aw_done || (s_awvalid && s_awready)) &&
          (w_done || (s_wvalid && s_wready))) begin
        b_pend <= 1'b1; b_cnt <= b_wait;
      end
      if (b_pend) begin
        if (b_cnt == 0) begin b_pend <= 1'b0; s_bvalid <= 1'b1; s_bresp <= bresp_cfg; end
        else b_cnt <= b_cnt - 1;
      end
      if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0; aw_done <= 1'b0; w_done <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_r0[$], exp_r1[$];
  logic [1:0]  exp_b0[$], exp_b1[$];
  logic ar0_f, aw0_f, w0_f, r0_f, b0_f, ar1_f, aw1_f, w1_f, r1_f, b1_f;

  task automatic clear_masters();
    m0_araddr = '0; m0_arsize = '0; m0_arvalid = 0; m0_rready = 1;
    m0_awaddr = '0; m0_awsize = '0; m0_awvalid = 0; m0_wdata = '0; m0_wstrb = '0; m0_wvalid = 0; m0_bready = 1;
    m1_araddr = '0; m1_arsize = '0; m1_arvalid = 0; m1_rready = 1;
    m1_awaddr = '0; m1_awsize = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 1;
    {ar0_f, aw0_f, w0_f, r0_f, b0_f, ar1_f, aw1_f, w1_f, r1_f, b1_f} = '0;
    exp_r0.delete(); exp_r1.delete(); exp_b0.delete(); exp_b1.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_masters();
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    rresp_cfg = RESP_OKAY; bresp_cfg = RESP_OKAY;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // One clock: drop valids that handshook last cycle, then record this cycle's handshakes.
  task automatic step();
    @(posedge clk); #1;
    if (ar0_f) m0_arvalid = 0;
    if (aw0_f) m0_awvalid = 0;
    if (w0_f)  m0_wvalid = 0;
    if (ar1_f) m1_arvalid = 0;
    if (aw1_f) m1_awvalid = 0;
    if (w1_f)  m1_wvalid = 0;
    @(negedge clk);
    ar0_f = m0_arvalid & m0_arready; aw0_f = m0_awvalid & m0_awready; w0_f = m0_wvalid & m0_wready;
    r0_f = m0_rvalid & m0_rready;    b0_f = m0_bvalid & m0_bready;
    ar1_f = m1_arvalid & m1_arready; aw1_f = m1_awvalid & m1_awready; w1_f = m1_wvalid & m1_wready;
    r1_f = m1_rvalid & m1_rready;    b1_f = m1_bvalid & m1_bready;
  endtask

  task automatic issue_rd(input logic m, input logic [31:0] addr);
    if (m) begin
      m1_araddr = addr; m1_arsize = 3'd1; m1_arvalid = 1'b1; exp_r1.push_back({rresp_cfg, addr ^ RKEY});
    end else begin
      m0_araddr = addr; m0_arsize = 3'd2; m0_arvalid = 1'b1; exp_r0.push_back({rresp_cfg, addr ^ RKEY});
    end
    #1;
  endtask

  task automatic issue_wr(input logic m, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (m) begin
      m1_awaddr = addr; m1_awsize = 3'd2; m1_wdata = data; m1_wstrb = strb;
      m1_awvalid = 1'b1; m1_wvalid = 1'b1; exp_b1.push_back(bresp_cfg);
    end else begin
      m0_awaddr = addr; m0_awsize = 3'd2; m0_wdata = data; m0_wstrb = strb;
      m0_awvalid = 1'b1; m0_wvalid = 1'b1; exp_b0.push_back(bresp_cfg);
    end
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] sv;
    logic [9:0] mv;
    rst = 1'b1;
    clear_masters();
    m0_arvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    repeat (2) @(negedge clk);
    sv = {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready};
    checks++;
    if (sv !== 5'b0) begin errors++; $display("FAIL reset_slave_side: got %b want 00000", sv); end
    mv = {m0_arready, m0_awready, m0_wready, m0_rvalid, m0_bvalid, m1_arready, m1_awready, m1_wready, m1_rvalid, m1_bvalid};
    checks++;
    if (mv !== 10'b0) begin errors++; $display("FAIL reset_master_side: got %b want 0", mv); end
    clear_masters();
    rst = 1'b0;
    step();
    sv = {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready};
    checks++;
    if (sv !== 5'b0) begin errors++; $display("FAIL idle_no_req: got %b want 00000", sv); end
  endtask

  task automatic test_single_read();
    logic [33:0] exp;
    int n;
    logic m1_bad;
    do_reset();
    issue_rd(0, 32'h8000_0000);
    checks++;
    if (s_arvalid !== 1'b0) begin errors++; $display("FAIL rd_cycle_n: s_arvalid got %b want 0", s_arvalid); end
    n = 0; m1_bad = 0;
    do begin
      step(); n++;
      if (m1_rvalid | m1_arready) m1_bad = 1;
      if (n == 1) begin
        checks++;
        if ({s_arvalid, s_araddr} !== {1'b1, 32'h8000_0000}) begin
          errors++; $display("FAIL rd_cycle_n1: got %b/%h want 1/80000000", s_arvalid, s_araddr);
        end
      end
    end while (!r0_f && n < 20);
    checks++;
    if (!r0_f) begin errors++; $display("FAIL rd_timeout: no m0 R handshake got %0d cycles", n); end
    else begin
      exp = exp_r0.pop_front();
      checks++;
      if ({m0_rresp, m0_rdata} !== exp) begin errors++; $display("FAIL rd_data: got %h want %h", {m0_rresp, m0_rdata}, exp); end
    end
    if (n !== 2) begin errors++; $display("FAIL rd_latency: R handshake at cycle %0d want 2", n); end
    checks++;
    if (m1_bad) begin errors++; $display("FAIL rd_m1_quiet: m1 saw rvalid/arready got 1 want 0"); end
    step();
    checks++;
    if ({s_arvalid, s_rready} !== 2'b00) begin errors++; $display("FAIL rd_back_idle: got %b want 00", {s_arvalid, s_rready}); end
  endtask

  task automatic test_tie();
    logic [33:0] exp;
    logic [1:0] eb;
    logic leak;
    do_reset();
    issue_rd(0, 32'h8000_0040);
    issue_wr(1, 32'h8000_0100, 32'hDEAD_BEEF, 4'hF);
    step();
    checks++;
    if ({s_arvalid, s_awvalid, s_wvalid} !== 3'b100) begin
      errors++; $display("FAIL tie_m0_first: ar/aw/w got %b want 100", {s_arvalid, s_awvalid, s_wvalid});
    end
    leak = 0;
    for (int i = 0; i < 20 && !r0_f; i++) begin
      if (i > 0) step();
      if (m1_awready | m1_wready | m1_bvalid) leak = 1;
    end
    checks++;
    if (!r0_f) begin errors++; $display("FAIL tie_rd_timeout: got no R want handshake"); end
    else begin
      exp = exp_r0.pop_front();
      checks++;
      if ({m0_rresp, m0_rdata} !== exp) begin errors++; $display("FAIL tie_rd_data: got %h want %h", {m0_rresp, m0_rdata}, exp); end
    end
    checks++;
    if (leak) begin errors++; $display("FAIL tie_m1_pending: m1 ready during M0 read got 1 want 0"); end
    step();
    checks++;
    if (s_awvalid !== 1'b0) begin errors++; $display("FAIL tie_bubble: s_awvalid got %b want 0", s_awvalid); end
    step();
    checks++;
    if ({s_awvalid, s_wvalid, s_awaddr, s_wdata, s_wstrb} !== {2'b11, 32'h8000_0100, 32'hDEAD_BEEF, 4'hF}) begin
      errors++; $display("FAIL tie_wr_fwd: got %b%b %h %h %h want 11 80000100 deadbeef f",
                        s_awvalid, s_wvalid, s_awaddr, s_wdata, s_wstrb);
    end
    for (int i = 0; i < 20 && !b1_f; i++) step();
    checks++;
    if (!b1_f) begin errors++; $display("FAIL tie_wr_timeout: got no B want handshake"); end
    else begin
      eb = exp_b1.pop_front();
      checks++;
      if (m1_bresp !== eb) begin errors++; $display("FAIL tie_wr_bresp: got %b want %b", m1_bresp, eb); end
    end
  endtask

  task automatic test_round_robin();
    logic [33:0] exp;
    logic got0, got1, order_ok;
    step();
    issue_rd(0, 32'h8000_0010);
    for (int i = 0; i < 20 && !r0_f; i++) step();
    checks++;
    if (!r0_f) begin errors++; $display("FAIL rr_pre_timeout: got no R want handshake"); end
    else begin
      exp = exp_r0.pop_front();
      if ({m0_rresp, m0_rdata} !== exp) begin errors++; $display("FAIL rr_pre_data: got %h want %h", {m0_rresp, m0_rdata}, exp); end
    end
    step();
    issue_rd(0, 32'h8000_0020);
    issue_rd(1, 32'h8000_0030);
    step();
    checks++;
    if ({s_arvalid, s_araddr, s_arsize, m0_arready} !== {1'b1, 32'h8000_0030, 3'd1, 1'b0}) begin
      errors++; $display("FAIL rr_m1_wins: got %b %h %0d %b want 1 80000030 1 0", s_arvalid, s_araddr, s_arsize, m0_arready);
    end
    got0 = 0; got1 = 0; order_ok = 1;
    for (int i = 0; i < 30 && !(got0 && got1); i++) begin
      if (i > 0) step();
      if (r1_f) begin
        got1 = 1; exp = exp_r1.pop_front();
        checks++;
        if ({m1_rresp, m1_rdata} !== exp) begin errors++; $display("FAIL rr_m1_data: got %h want %h", {m1_rresp, m1_rdata}, exp); end
      end
      if (r0_f) begin
        if (!got1) order_ok = 0;
        got0 = 1; exp = exp_r0.pop_front();
        checks++;
        if ({m0_rresp, m0_rdata} !== exp) begin errors++; $display("FAIL rr_m0_data: got %h want %h", {m0_rresp, m0_rdata}, exp); end
      end
    end
    checks++;
    if (!(got0 && got1 && order_ok)) begin
      errors++; $display("FAIL rr_order: got m0=%b m1=%b order=%b want 1 1 1", got0, got1, order_ok);
    end
  endtask

  task automatic test_write_stall();
    logic [33:0] exp;
    logic [1:0] eb;
    int aw_at, w_at, b_at;
    logic leak, hold_bad;
    do_reset();
    aw_wait = 0; w_wait = 2; b_wait = 1;
    issue_wr(1, 32'h8000_0200, 32'h0BAD_F00D, 4'b0101);
    aw_at = -1; w_at = -1; b_at = -1; leak = 0; hold_bad = 0;
    for (int i = 1; i <= 30 && b_at < 0; i++) begin
      step();
      if (i == 1) issue_rd(0, 32'h8000_0300);
      if (aw1_f && aw_at < 0) aw_at = i;
      if (w1_f && w_at < 0) w_at = i;
      if (m0_arready || s_arvalid) leak = 1;
      if (!s_bready) hold_bad = 1;
      if (b1_f) begin
        b_at = i; eb = exp_b1.pop_front();
        checks++;
        if (m1_bresp !== eb) begin errors++; $display("FAIL stall_bresp: got %b want %b", m1_bresp, eb); end
      end
    end
    checks++;
    if (b_at < 0) begin errors++; $display("FAIL stall_b_timeout: got no B want handshake"); end
    checks++;
    if (w_at - aw_at !== 2) begin errors++; $display("FAIL stall_aw_w_gap: got %0d want 2", w_at - aw_at); end
    checks++;
    if (hold_bad) begin errors++; $display("FAIL stall_grant_held: grant dropped before B got 1 want 0"); end
    checks++;
    if (leak) begin errors++; $display("FAIL stall_m0_blocked: M0 read reached slave mid-write got 1 want 0"); end
    checks++;
    if ({log_awaddr, log_wdata, log_wstrb} !== {32'h8000_0200, 32'h0BAD_F00D, 4'b0101}) begin
      errors++; $display("FAIL stall_wr_payload: got %h %h %b want 80000200 0badf00d 0101", log_awaddr, log_wdata, log_wstrb);
    end
    for (int i = 0; i < 20 && !r0_f; i++) step();
    checks++;
    if (!r0_f) begin errors++; $display("FAIL stall_rd_timeout: got no R want handshake"); end
    else begin
      exp = exp_r0.pop_front();
      checks++;
      if ({m0_rresp, m0_rdata} !== exp) begin errors++; $display("FAIL stall_rd_data: got %h want %h", {m0_rresp, m0_rdata}, exp); end
    end
  endtask

  task automatic test_error_resp();
    logic [33:0] exp;
    logic [1:0] eb;
    logic got0r, got0b;
    do_reset();
    bresp_cfg = RESP_SLVERR;
    issue_wr(1, 32'h8000_0600, 32'h1111_2222, 4'hC);
    for (int i = 0; i < 20 && !b1_f; i++) step();
    checks++;
    if (!b1_f) begin errors++; $display("FAIL slverr_timeout: got no B want handshake"); end
    else begin
      eb = exp_b1.pop_front();
      checks++;
      if (m1_bresp !== eb) begin errors++; $display("FAIL slverr_bresp: got %b want %b", m1_bresp, eb); end
    end
    step();
    checks++;
    if ({s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready} !== 5'b0) begin
      errors++; $display("FAIL slverr_idle: got %b want 00000", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready});
    end
    bresp_cfg = RESP_OKAY; rresp_cfg = RESP_DECERR;
    issue_wr(0, 32'h8000_0700, 32'h3333_4444, 4'h3);
    issue_rd(0, 32'h8000_0800);
    step();
    checks++;
    if ({s_awvalid, s_arvalid, s_awaddr} !== {2'b10, 32'h8000_0700}) begin
      errors++; $display("FAIL wr_beats_rd: got %b%b %h want 10 80000700", s_awvalid, s_arvalid, s_awaddr);
    end
    got0r = 0; got0b = 0;
    for (int i = 0; i < 30 && !(got0r && got0b); i++) begin
      if (i > 0) step();
      if (b0_f) begin
        got0b = 1; eb = exp_b0.pop_front();
        checks++;
        if (m0_bresp !== eb) begin errors++; $display("FAIL m0_wr_bresp: got %b want %b", m0_bresp, eb); end
      end
      if (r0_f) begin
        got0r = 1; exp = exp_r0.pop_front();
        checks++;
        if ({m0_rresp, m0_rdata} !== exp) begin errors++; $display("FAIL decerr_rd: got %h want %h", {m0_rresp, m0_rdata}, exp); end
      end
    end
    checks++;
    if (!(got0r && got0b)) begin errors++; $display("FAIL m0_wr_rd_timeout: got r=%b b=%b want 1 1", got0r, got0b); end
  endtask

  task automatic test_reset_mid();
    logic [33:0] exp;
    logic [4:0] sv;
    do_reset();
    ar_wait = 5;
    issue_rd(1, 32'h8000_0400);
    step(); step();
    checks++;
    if ({s_arvalid, s_araddr} !== {1'b1, 32'h8000_0400}) begin
      errors++; $display("FAIL pre_rst_rd1: got %b %h want 1 80000400", s_arvalid, s_araddr);
    end
    rst = 1'b1;
    clear_masters();
    @(posedge clk); #1;
    sv = {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready};
    checks++;
    if (sv !== 5'b0) begin errors++; $display("FAIL rst_mid_slave: got %b want 00000", sv); end
    @(negedge clk);
    rst = 1'b0;
    ar_wait = 0;
    #1;
    issue_rd(1, 32'h8000_0500);
    for (int i = 0; i < 20 && !r1_f; i++) step();
    checks++;
    if (!r1_f) begin errors++; $display("FAIL rst_mid_rd_timeout: got no R want handshake"); end
    else begin
      exp = exp_r1.pop_front();
      checks++;
      if ({m1_rresp, m1_rdata} !== exp) begin errors++; $display("FAIL rst_mid_rd_data: got %h want %h", {m1_rresp, m1_rdata}, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_round_robin();
    test_write_stall();
    test_error_resp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
